serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor, LSB first: diff = a - b, with final borrow out.
- Inverse-direction companion to the 1-bit full adder cell.
- Reuses a single full-subtractor cell plus a borrow flip-flop, iterated over WIDTH cycles.
- Operands are loaded in parallel on a start handshake. Result is presented in parallel with a one-cycle done pulse.

---
 rtl/serial_subtractor.sv | 116 +++++++++++
 tb/tb_serial_subtractor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b, LSB first) using one full-subtractor cell.
// Optional SERIAL_SUBTRACTOR_ADD_MODE_EN adds a 'mode' input selecting a + b (carry on bout).
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  input  logic             mode,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CntW-1:0]  r_count;
  logic             r_borrow;
  logic             r_bout;
  logic             w_load;
  logic             w_last;
  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_br_next;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic             r_mode;
`endif

  // A new operation may be loaded from IDLE or directly from DONE.
  assign w_load = start && ((r_state == StIdle) || (r_state == StDone));
  assign w_last = (r_count == CntW'(WIDTH - 1));

  always_comb begin
    w_x       = r_a[0];
    w_y       = r_b[0];
    w_d       = w_x ^ w_y ^ r_borrow;
    w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    if (r_mode) begin
      w_br_next = (w_x & w_y) | (r_borrow & (w_x ^ w_y));
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StShift;
      StShift: if (w_last) w_state_next = StDone;
      StDone:  w_state_next = start ? StShift : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy = (r_state == StShift);
    done = (r_state == StDone);
    diff = r_diff;
    bout = r_bout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_count  <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      r_mode   <= 1'b0;
`endif
    end else if (w_load) begin
      r_a      <= a;
      r_b      <= b;
      r_diff   <= '0;
      r_count  <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      r_mode   <= mode;
`endif
    end else if (r_state == StShift) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_diff   <= {w_d, r_diff[WIDTH-1:1]};
      r_borrow <= w_br_next;
      r_count  <= r_count + CntW'(1);
      if (w_last) begin
        r_bout <= w_br_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic/timestamp model checked every cycle plus literal vectors.
`timescale 1ns/1ps
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic         mode  = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    .mode  (mode),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: operation accepted at edge m_acc is busy for W cycles, then done for one cycle.
  int           edge_cnt = 0;
  int           m_acc    = 0;
  bit           m_active = 1'b0;
  bit           can_acc;
  logic [W-1:0] m_diff   = '0;
  logic         m_bout   = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_active = 1'b0;
      m_diff   = '0;
      m_bout   = 1'b0;
    end else begin
      edge_cnt++;
      can_acc = !m_active || (edge_cnt - m_acc > int'(W));
      if (start && can_acc) begin
        m_acc    = edge_cnt;
        m_active = 1'b1;
        m_diff   = a - b;
        m_bout   = (a < b);
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        if (mode) {m_bout, m_diff} = {1'b0, a} + {1'b0, b};
`endif
      end else if (m_active && (edge_cnt - m_acc > int'(W))) begin
        m_active = 1'b0;
      end
    end
  end

  initial forever begin
    int  s;
    bit  e_busy;
    bit  e_done;
    @(negedge clk);
    s      = edge_cnt - m_acc;
    e_busy = m_active && (s < int'(W));
    e_done = m_active && (s == int'(W));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    if (!e_busy) begin
      chk("diff", 32'(diff), 32'(m_diff));
      chk("bout", 32'(bout), 32'(m_bout));
    end
  end

  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic im,
                       output int lat);
    @(negedge clk);
    a = ia;
    b = ib;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    mode = im;
`else
    if (im) $display("note: add mode requested but not built");
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done timeout: got no done, expected one within 20 cycles at %0t", $time);
    end
  endtask

  logic [W-1:0] btab [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0F, 8'h10, 8'h55, 8'h7E,
                              8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC3, 8'hF0, 8'hFE, 8'hFF};

  initial begin
    int lat;
    int ndone;
    bit got;
    #1 rst = 1'b1;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset diff", 32'(diff), 32'd0);
    chk("reset bout", 32'(bout), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic vectors.
    do_op(8'h05, 8'h03, 1'b0, lat);
    chk("t1 latency", 32'(lat), 32'd8);
    chk("t1 diff", 32'(diff), 32'h02);
    chk("t1 bout", 32'(bout), 32'd0);
    repeat (3) @(negedge clk);
    chk("t1 held diff", 32'(diff), 32'h02);
    chk("t1 held bout", 32'(bout), 32'd0);

    do_op(8'h03, 8'h05, 1'b0, lat);
    chk("t2a diff", 32'(diff), 32'hFE);
    chk("t2a bout", 32'(bout), 32'd1);
    do_op(8'h00, 8'h00, 1'b0, lat);
    chk("t2b diff", 32'(diff), 32'h00);
    chk("t2b bout", 32'(bout), 32'd0);
    do_op(8'h80, 8'h01, 1'b0, lat);
    chk("t2c diff", 32'(diff), 32'h7F);
    chk("t2c bout", 32'(bout), 32'd0);

    // Back-to-back sweep: every a against a table of b values, restarting in the done cycle.
    @(negedge clk);
    a     = 8'h00;
    b     = btab[0];
    start = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      got = 1'b0;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        if (done) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        n_cmp++;
        n_err++;
        $display("FAIL sweep timeout: got no done, expected one for op %0d", i);
        break;
      end
      if (i < 4095) begin
        a = 8'(i + 1);
        b = btab[(i + 1) / 256];
      end
    end
    start = 1'b0;
    chk("sweep last diff", 32'(diff), 32'(8'hFF - 8'hFF));
    chk("sweep last bout", 32'(bout), 32'd0);
    repeat (2) @(negedge clk);

    // Start while busy is ignored.
    @(negedge clk);
    a     = 8'h10;
    b     = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a     = 8'hAA;
    b     = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("t4 latency", 32'(lat), 32'd5);
    chk("t4 diff", 32'(diff), 32'h0F);
    chk("t4 bout", 32'(bout), 32'd0);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    a     = 8'h33;
    b     = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5 rst busy", 32'(busy), 32'd0);
    chk("t5 rst done", 32'(done), 32'd0);
    chk("t5 rst diff", 32'(diff), 32'd0);
    chk("t5 rst bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t5 no done", 32'(ndone), 32'd0);
    do_op(8'h09, 8'h04, 1'b0, lat);
    chk("t5 diff", 32'(diff), 32'h05);
    chk("t5 bout", 32'(bout), 32'd0);

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    do_op(8'hFF, 8'h01, 1'b1, lat);
    chk("t6 add diff", 32'(diff), 32'h00);
    chk("t6 add bout", 32'(bout), 32'd1);
    do_op(8'hFF, 8'h01, 1'b0, lat);
    chk("t6 sub diff", 32'(diff), 32'hFE);
    chk("t6 sub bout", 32'(bout), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
